// File: rtl/peripheral_dsa_vector_modular_adder_if.sv
// ----------------------------------------------------------------------------
// peripheral_dsa_vector_modular_adder_if
//   Handshake bundle of the vector modular adder.
//   master : the block feeding operands and consuming results
//   slave  : the vector modular adder itself
//   Signals
//     START, OPERATION, MODULO, SIZE_IN          vector launch and its settings
//     DATA_A_IN/_ENABLE, DATA_B_IN/_ENABLE       element operands with valids
//     DATA_ENABLE                                request for the next element pair
//     DATA_OUT, DATA_OUT_ENABLE                  element result with its strobe
//     READY                                      vector completion strobe
// ----------------------------------------------------------------------------
interface peripheral_dsa_vector_modular_adder_if #(
  parameter int DATA_SIZE = 64,
  parameter int SIZE_I    = 4
);
  localparam int SIZE_W = $clog2(SIZE_I + 1);

  logic                 START;
  logic                 OPERATION;
  logic [DATA_SIZE-1:0] MODULO;
  logic [SIZE_W-1:0]    SIZE_IN;
  logic [DATA_SIZE-1:0] DATA_A_IN;
  logic [DATA_SIZE-1:0] DATA_B_IN;
  logic                 DATA_A_IN_ENABLE;
  logic                 DATA_B_IN_ENABLE;
  logic                 DATA_ENABLE;
  logic [DATA_SIZE-1:0] DATA_OUT;
  logic                 DATA_OUT_ENABLE;
  logic                 READY;

  modport master (
    output START, OPERATION, MODULO, SIZE_IN,
    output DATA_A_IN, DATA_B_IN, DATA_A_IN_ENABLE, DATA_B_IN_ENABLE,
    input  DATA_ENABLE, DATA_OUT, DATA_OUT_ENABLE, READY
  );

  modport slave (
    input  START, OPERATION, MODULO, SIZE_IN,
    input  DATA_A_IN, DATA_B_IN, DATA_A_IN_ENABLE, DATA_B_IN_ENABLE,
    output DATA_ENABLE, DATA_OUT, DATA_OUT_ENABLE, READY
  );
endinterface

// File: rtl/peripheral_dsa_vector_modular_adder.sv
// ----------------------------------------------------------------------------
// peripheral_dsa_vector_modular_adder
//   Element-wise modular add / subtract over a vector of up to SIZE_I pairs.
//   Each pair is requested with DATA_ENABLE, collected in any order, reduced
//   with a single correction step against the latched modulus and emitted on
//   DATA_OUT with DATA_OUT_ENABLE; READY accompanies the last element.
//   Ports
//     CLK    clock, rising edge
//     RST    asynchronous active-high reset
//     bus    peripheral_dsa_vector_modular_adder_if.slave handshake bundle
//     ERROR  (only with PERIPHERAL_DSA_RANGE_ERROR_EN defined) sticky flag for
//            MODULO==0 at START or a captured operand >= modulus
//   Build option: PERIPHERAL_DSA_RANGE_ERROR_EN
// ----------------------------------------------------------------------------
module peripheral_dsa_vector_modular_adder #(
  parameter int DATA_SIZE = 64,
  parameter int SIZE_I    = 4
) (
  input  logic CLK,
  input  logic RST,
`ifdef PERIPHERAL_DSA_RANGE_ERROR_EN
  output logic ERROR,
`endif
  peripheral_dsa_vector_modular_adder_if.slave bus
);

  localparam int SIZE_W = $clog2(SIZE_I + 1);
  localparam logic [SIZE_W-1:0] SIZE_MAX = SIZE_W'(SIZE_I);
  localparam logic [SIZE_W-1:0] ONE      = SIZE_W'(1);

  typedef enum logic [1:0] {STARTER, INPUT_STATE, ENDER_STATE} state_t;

  state_t               state_q, state_d;
  logic                 op_q, op_d;
  logic [DATA_SIZE-1:0] mod_q, mod_d;
  logic [SIZE_W-1:0]    n_q, n_d;
  logic [SIZE_W-1:0]    idx_q, idx_d;
  logic [DATA_SIZE-1:0] a_q, a_d, b_q, b_d;
  logic                 a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [DATA_SIZE-1:0] out_q, out_d;
  logic                 doe_q, doe_d, de_q, de_d, ready_q, ready_d;
  logic [SIZE_W-1:0]    n_clamp;
  logic                 a_take, b_take;
`ifdef PERIPHERAL_DSA_RANGE_ERROR_EN
  logic                 error_q, error_d;
`endif

  // One correction step only: operands already >= M are not fully reduced.
  function automatic logic [DATA_SIZE-1:0] mod_add(
    input logic [DATA_SIZE-1:0] a, input logic [DATA_SIZE-1:0] b,
    input logic [DATA_SIZE-1:0] m);
    logic [DATA_SIZE:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[DATA_SIZE-1:0];
  endfunction

  function automatic logic [DATA_SIZE-1:0] mod_sub(
    input logic [DATA_SIZE-1:0] a, input logic [DATA_SIZE-1:0] b,
    input logic [DATA_SIZE-1:0] m);
    logic signed [DATA_SIZE:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d[DATA_SIZE]) d = d + $signed({1'b0, m});
    return d[DATA_SIZE-1:0];
  endfunction

  assign n_clamp = (bus.SIZE_IN > SIZE_MAX) ? SIZE_MAX : bus.SIZE_IN;
  assign a_take  = bus.DATA_A_IN_ENABLE && !a_vld_q;
  assign b_take  = bus.DATA_B_IN_ENABLE && !b_vld_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mod_d   = mod_q;
    n_d     = n_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    a_vld_d = a_vld_q;
    b_vld_d = b_vld_q;
    out_d   = out_q;
    doe_d   = 1'b0;
    de_d    = 1'b0;
    ready_d = 1'b0;
`ifdef PERIPHERAL_DSA_RANGE_ERROR_EN
    error_d = error_q;
`endif
    case (state_q)
      STARTER: begin
        if (bus.START) begin
`ifdef PERIPHERAL_DSA_RANGE_ERROR_EN
          error_d = (bus.MODULO == '0);
`endif
          if (bus.SIZE_IN == '0) begin
            ready_d = 1'b1;
          end else begin
            op_d    = bus.OPERATION;
            mod_d   = bus.MODULO;
            n_d     = n_clamp;
            idx_d   = '0;
            a_vld_d = 1'b0;
            b_vld_d = 1'b0;
            de_d    = 1'b1;
            state_d = INPUT_STATE;
          end
        end
      end
      INPUT_STATE: begin
        if (a_take) begin
          a_d     = bus.DATA_A_IN;
          a_vld_d = 1'b1;
`ifdef PERIPHERAL_DSA_RANGE_ERROR_EN
          if (bus.DATA_A_IN >= mod_q) error_d = 1'b1;
`endif
        end
        if (b_take) begin
          b_d     = bus.DATA_B_IN;
          b_vld_d = 1'b1;
`ifdef PERIPHERAL_DSA_RANGE_ERROR_EN
          if (bus.DATA_B_IN >= mod_q) error_d = 1'b1;
`endif
        end
        if ((a_vld_q || bus.DATA_A_IN_ENABLE) && (b_vld_q || bus.DATA_B_IN_ENABLE))
          state_d = ENDER_STATE;
      end
      ENDER_STATE: begin
        out_d   = op_q ? mod_sub(a_q, b_q, mod_q) : mod_add(a_q, b_q, mod_q);
        doe_d   = 1'b1;
        a_vld_d = 1'b0;
        b_vld_d = 1'b0;
        if (idx_q + ONE == n_q) begin
          ready_d = 1'b1;
          state_d = STARTER;
        end else begin
          idx_d   = idx_q + ONE;
          de_d    = 1'b1;
          state_d = INPUT_STATE;
        end
      end
      default: state_d = STARTER;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= STARTER;
      op_q    <= 1'b0;
      mod_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      out_q   <= '0;
      doe_q   <= 1'b0;
      de_q    <= 1'b0;
      ready_q <= 1'b0;
`ifdef PERIPHERAL_DSA_RANGE_ERROR_EN
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mod_q   <= mod_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      out_q   <= out_d;
      doe_q   <= doe_d;
      de_q    <= de_d;
      ready_q <= ready_d;
`ifdef PERIPHERAL_DSA_RANGE_ERROR_EN
      error_q <= error_d;
`endif
    end
  end

  assign bus.DATA_OUT        = out_q;
  assign bus.DATA_OUT_ENABLE = doe_q;
  assign bus.DATA_ENABLE     = de_q;
  assign bus.READY           = ready_q;
`ifdef PERIPHERAL_DSA_RANGE_ERROR_EN
  assign ERROR = error_q;
`endif

endmodule

// File: doc/peripheral_dsa_vector_modular_adder.md
PERIPHERAL_DSA_VECTOR_MODULAR_ADDER -- requirements
Module: peripheral_dsa_vector_modular_adder

Interface
REQ-001 Parameter DATA_SIZE, default 64, SHALL set the operand, modulus and result width in bits.
REQ-002 Parameter SIZE_I, default 4, SHALL set the maximum vector length; it SHALL be at least 1.
REQ-003 CLK  input  1  SHALL be the single clock; every register SHALL update on the rising edge.
REQ-004 RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 START  input  1  SHALL be a one-cycle pulse that launches a vector operation.
REQ-006 OPERATION  input  1  SHALL select the operation: 0 = modular add, 1 = modular subtract.
REQ-007 MODULO  input  DATA_SIZE  SHALL be the modulus M.
REQ-008 SIZE_IN  input  clog2(SIZE_I+1)  SHALL be the vector length N.
REQ-009 DATA_A_IN / DATA_B_IN  input  DATA_SIZE  SHALL carry the element operands.
REQ-010 DATA_A_IN_ENABLE / DATA_B_IN_ENABLE  input  1  SHALL mark the matching operand as valid.
REQ-011 DATA_ENABLE  output  1  SHALL be a one-cycle request for the next element pair.
REQ-012 DATA_OUT  output  DATA_SIZE  SHALL carry the element result.
REQ-013 DATA_OUT_ENABLE  output  1  SHALL be a one-cycle pulse marking DATA_OUT as valid.
REQ-014 READY  output  1  SHALL be a one-cycle pulse marking vector completion.

Function
REQ-015 The FSM SHALL have three states: STARTER (idle), INPUT_STATE (wait for operands) and ENDER_STATE (compute and emit).
REQ-016 In STARTER, START=1 with 1<=N<=SIZE_I SHALL latch OPERATION, MODULO and N, clear the element index, pulse DATA_ENABLE on the next cycle and enter INPUT_STATE.
REQ-017 START with N=0 SHALL pulse READY on the next cycle, produce no DATA_OUT_ENABLE and remain in STARTER.
REQ-018 START with N>SIZE_I SHALL be treated as N=SIZE_I.
REQ-019 START SHALL be ignored outside STARTER; the latched OPERATION and MODULO SHALL be used for the whole vector.
REQ-020 In INPUT_STATE, each operand SHALL be captured on the first cycle its enable is high.
REQ-021 A and B MAY arrive in the same cycle or in different cycles.
REQ-022 A repeated enable for an operand already captured SHALL be ignored.
REQ-023 The edge that completes the pair SHALL move the FSM to ENDER_STATE.
REQ-024 In ENDER_STATE, the result SHALL be registered in one cycle, and DATA_OUT_ENABLE SHALL be high in the cycle after that edge.
REQ-025 Latency from the edge that completes the pair to DATA_OUT_ENABLE SHALL be 2 cycles.
REQ-026 Add SHALL compute S=A+B in DATA_SIZE+1 bits; the result SHALL be S-M if S>=M, else S.
REQ-027 Subtract SHALL compute D=A-B in DATA_SIZE+1 bits; the result SHALL be D+M if D<0, else D.
REQ-028 Both results SHALL be truncated to DATA_SIZE bits.
REQ-029 Operands >=M SHALL still receive exactly one correction step; the result is defined by REQ-026/027 but is not guaranteed to be reduced.
REQ-030 After each non-final element, the index SHALL increment, DATA_ENABLE SHALL pulse in the same cycle as DATA_OUT_ENABLE, and the FSM SHALL return to INPUT_STATE.
REQ-031 After element N-1, READY SHALL pulse in the same cycle as the last DATA_OUT_ENABLE, and the FSM SHALL return to STARTER.
REQ-032 A new START SHALL be accepted in the cycle after READY.
REQ-033 DATA_OUT SHALL hold its last value until the next result.

Reset
REQ-034 RST=1 SHALL immediately force the FSM to STARTER and clear the index and captured operands.
REQ-035 RST=1 SHALL force DATA_OUT=0, DATA_OUT_ENABLE=0, DATA_ENABLE=0 and READY=0, including mid-vector.
REQ-036 Reset SHALL produce no READY pulse.
REQ-037 After RST deasserts, the block SHALL accept START on the first rising edge.

Configuration
REQ-038 The macro PERIPHERAL_DSA_RANGE_ERROR_EN SHALL control an extra output port ERROR (1 bit).
REQ-039 With the macro defined, ERROR SHALL be set when MODULO==0 at START, or when any captured operand is >=M.
REQ-040 With the macro defined, ERROR SHALL be sticky until the next accepted START or reset, and SHALL reset to 0.
REQ-041 With the macro undefined, the ERROR port and its check logic SHALL be absent, and function SHALL otherwise be identical.

Verification
REQ-042 Scenario: DATA_SIZE=8, M=13, add, N=3, pairs (5,7),(9,6),(12,12) -> DATA_OUT 12, 2, 11, with READY on the third DATA_OUT_ENABLE.
REQ-043 Scenario: subtract, M=13, pairs (3,8),(8,3) -> DATA_OUT 8, 5.
REQ-044 Scenario: A enabled 3 cycles before B, with a second A enable in between -> the first A is used, and DATA_OUT_ENABLE arrives 2 cycles after the B capture.
REQ-045 Scenario: START with N=0 -> READY one cycle later, with no DATA_ENABLE and no DATA_OUT_ENABLE.
REQ-046 Scenario: RST pulsed during element 2 of 4 -> all outputs 0 at once, no READY, and the next START with N=2 completes normally.
REQ-047 Scenario (with the macro defined): M=13 with A=14 -> ERROR=1 until the next START; DATA_OUT follows REQ-026.
